// File: rtl/axi_arbiter_w.sv
// ---------------------------------------------------------------------------
// axi_arbiter_w
// Write-path arbiter for the two-master AXI interconnect. One master owns the
// shared AW/W/B path for a whole write transaction: address, every data beat
// and the write response. Ownership is released only after the B handshake.
// Contention is resolved round-robin: the master that did not win last time
// wins. All outputs are decoded from registers only, so the grants never have
// a combinational path from the request inputs.
// ---------------------------------------------------------------------------
module axi_arbiter_w #(
    parameter int MAX_BEATS = 256,  // W beats allowed per burst before overrun
    parameter int BEAT_W    = 9     // beat counter width, 2**BEAT_W > MAX_BEATS
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic m0_AWVALID,
    input  logic m1_AWVALID,
    input  logic s_AWREADY,
    input  logic m_WVALID,
    input  logic m_WLAST,
    input  logic s_WREADY,
    input  logic s_BVALID,
    input  logic m_BREADY,
    output logic m0_wgrnt,
    output logic m1_wgrnt,
    output logic wr_busy,
    output logic wr_err
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE      = 2'b00;
    localparam logic [1:0] S_ADDR_DATA = 2'b01;
    localparam logic [1:0] S_RESP      = 2'b10;

    // Highest value the beat counter may hold; it saturates here.
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_owner;       // 0: master 0 owns the path, 1: master 1
    logic              r_last_owner;  // owner of the last completed transaction
    logic              r_aw_done;     // address phase of current burst finished
    logic              r_w_done;      // WLAST beat of current burst accepted
    logic [BEAT_W-1:0] r_beat_cnt;    // W beats accepted in current burst
    logic              r_wr_err;      // sticky overrun flag

    // -----------------------------------------------------------------------
    // Decoded state and handshakes
    // -----------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_in_idle;
    logic       w_in_addr_data;
    logic       w_in_resp;
    logic       w_req_any;
    logic       w_winner;
    logic       w_owner_awvalid;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_wlast_hs;
    logic       w_b_hs;
    logic       w_aw_complete;
    logic       w_w_complete;
    logic       w_beat_at_last;
    logic       w_overrun;

    assign w_in_idle      = (r_state == S_IDLE);
    assign w_in_addr_data = (r_state == S_ADDR_DATA);
    assign w_in_resp      = (r_state == S_RESP);

    assign w_req_any = m0_AWVALID | m1_AWVALID;

    // Single requester wins outright; on contention the master that did not
    // own the previous transaction wins.
    assign w_winner = (m0_AWVALID && m1_AWVALID) ? ~r_last_owner : m1_AWVALID;

    // Only the granted master's AWVALID matters once the path is owned.
    assign w_owner_awvalid = r_owner ? m1_AWVALID : m0_AWVALID;

    // Handshakes are qualified by state so stray traffic outside the phase it
    // belongs to (e.g. a B handshake during ADDR_DATA) has no effect. Once a
    // phase has completed, further handshakes on it are ignored as well.
    assign w_aw_hs    = w_in_addr_data && !r_aw_done && w_owner_awvalid && s_AWREADY;
    assign w_w_hs     = w_in_addr_data && !r_w_done && m_WVALID && s_WREADY;
    assign w_wlast_hs = w_w_hs && m_WLAST;
    assign w_b_hs     = w_in_resp && s_BVALID && m_BREADY;

    // Phase completion includes a handshake happening in this very cycle so
    // the AW and W phases may finish in either order or together.
    assign w_aw_complete = r_aw_done | w_aw_hs;
    assign w_w_complete  = r_w_done  | w_wlast_hs;

    // A non-final beat arriving when the counter is already at its limit means
    // the burst is longer than MAX_BEATS.
    assign w_beat_at_last = (r_beat_cnt == BEAT_LAST);
    assign w_overrun      = w_w_hs && !m_WLAST && w_beat_at_last;

    // -----------------------------------------------------------------------
    // Next-state logic for the transaction FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = S_ADDR_DATA;
                end
            end
            S_ADDR_DATA: begin
                if (w_aw_complete && w_w_complete) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner is captured at arbitration and held until the path is released.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_owner <= 1'b0;
        end else if (w_in_idle && w_req_any) begin
            r_owner <= w_winner;
        end
    end

    // Round-robin history; resets to master 1 so master 0 wins first contention.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_last_owner <= 1'b1;
        end else if (w_b_hs) begin
            r_last_owner <= r_owner;
        end
    end

    // Address-phase completion flag, cleared while idle for the next burst.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_aw_done <= 1'b0;
        end else if (w_in_idle) begin
            r_aw_done <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_done <= 1'b1;
        end
    end

    // Data-phase completion flag, set by the beat that carries WLAST.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_w_done <= 1'b0;
        end else if (w_in_idle) begin
            r_w_done <= 1'b0;
        end else if (w_wlast_hs) begin
            r_w_done <= 1'b1;
        end
    end

    // Beat counter, saturating at MAX_BEATS-1 so it can never wrap.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_beat_cnt <= '0;
        end else if (w_in_idle) begin
            r_beat_cnt <= '0;
        end else if (w_w_hs && !w_beat_at_last) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        end
    end

    // Sticky overrun flag; only reset clears it. The burst itself continues
    // until WLAST so the slave and master stay in step.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wr_err <= 1'b0;
        end else if (w_overrun) begin
            r_wr_err <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registers only
    // -----------------------------------------------------------------------
    assign wr_busy  = w_in_addr_data | w_in_resp;
    assign m0_wgrnt = wr_busy & ~r_owner;
    assign m1_wgrnt = wr_busy &  r_owner;
    assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// ---------------------------------------------------------------------------
// tb_axi_arbiter_w
// Directed stimulus for the write-path arbiter. Each stimulus step drives the
// inputs for one clock and queues the hand-computed outputs expected after
// that edge; an independent monitor pops and compares after every edge.
// Expected vector order: {m0_wgrnt, m1_wgrnt, wr_busy, wr_err}.
// Stimulus vector order: {ARESETn, m0_AWVALID, m1_AWVALID, s_AWREADY,
//                         m_WVALID, m_WLAST, s_WREADY, s_BVALID, m_BREADY}.
// ---------------------------------------------------------------------------
module tb_axi_arbiter_w;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic m0_AWVALID = 1'b0;
    logic m1_AWVALID = 1'b0;
    logic s_AWREADY = 1'b0;
    logic m_WVALID = 1'b0;
    logic m_WLAST = 1'b0;
    logic s_WREADY = 1'b0;
    logic s_BVALID = 1'b0;
    logic m_BREADY = 1'b0;
    logic m0_wgrnt;
    logic m1_wgrnt;
    logic wr_busy;
    logic wr_err;

    int errors = 0;
    int checks = 0;

    string      name_q[$];
    logic [3:0] exp_q[$];

    axi_arbiter_w #(
        .MAX_BEATS (4),
        .BEAT_W    (3)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m0_AWVALID (m0_AWVALID),
        .m1_AWVALID (m1_AWVALID),
        .s_AWREADY  (s_AWREADY),
        .m_WVALID   (m_WVALID),
        .m_WLAST    (m_WLAST),
        .s_WREADY   (s_WREADY),
        .s_BVALID   (s_BVALID),
        .m_BREADY   (m_BREADY),
        .m0_wgrnt   (m0_wgrnt),
        .m1_wgrnt   (m1_wgrnt),
        .wr_busy    (wr_busy),
        .wr_err     (wr_err)
    );

    always #5 ACLK = ~ACLK;

    // Drive one cycle of stimulus and queue the outputs expected after it.
    task automatic step(input string nm, input logic [8:0] v, input logic [3:0] e);
        @(negedge ACLK);
        {ARESETn, m0_AWVALID, m1_AWVALID, s_AWREADY,
         m_WVALID, m_WLAST, s_WREADY, s_BVALID, m_BREADY} = v;
        name_q.push_back(nm);
        exp_q.push_back(e);
    endtask

    // Monitor: compare outputs just after each rising edge against the queue.
    initial begin
        logic [3:0] e;
        logic [3:0] got;
        string      nm;
        forever begin
            @(posedge ACLK);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {m0_wgrnt, m1_wgrnt, wr_busy, wr_err};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got {m0,m1,busy,err}=%b required %b", nm, got, e);
                end
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Single master, 4-beat burst ending exactly at the beat limit.
        step("t1_reset",      9'b0_00_0_000_00, 4'b0000);
        step("t1_grant_m0",   9'b1_10_0_000_00, 4'b1010);
        step("t1_aw",         9'b1_10_1_000_00, 4'b1010);
        step("t1_w1",         9'b1_00_0_101_00, 4'b1010);
        step("t1_w2",         9'b1_00_0_101_00, 4'b1010);
        step("t1_w3",         9'b1_00_0_101_00, 4'b1010);
        step("t1_w4_last",    9'b1_00_0_111_00, 4'b1010);
        step("t1_resp_wait",  9'b1_00_0_000_00, 4'b1010);
        step("t1_b",          9'b1_00_0_000_11, 4'b0000);
        step("t1_idle",       9'b1_00_0_000_00, 4'b0000);

        // Both requesting from reset: m0, then m1, then m0 again.
        step("t2_reset",      9'b0_11_0_000_00, 4'b0000);
        step("t2_grant_m0",   9'b1_11_0_000_00, 4'b1010);
        step("t2_aw",         9'b1_11_1_000_00, 4'b1010);
        step("t2_w_last",     9'b1_11_0_111_00, 4'b1010);
        step("t2_b_m0",       9'b1_11_0_000_11, 4'b0000);
        step("t2_grant_m1",   9'b1_11_0_000_00, 4'b0110);
        step("t2_m1_aw_last", 9'b1_11_1_111_00, 4'b0110);
        step("t2_b_m1",       9'b1_11_0_000_11, 4'b0000);
        step("t2_grant_m0_2", 9'b1_11_0_000_00, 4'b1010);
        step("t2_m0_aw_last", 9'b1_11_1_111_00, 4'b1010);
        step("t2_b_m0_2",     9'b1_00_0_000_11, 4'b0000);
        step("t2_idle",       9'b1_00_0_000_00, 4'b0000);

        // WLAST before AW; a B handshake during ADDR_DATA must be ignored.
        step("t3_grant_m0",   9'b1_10_0_000_00, 4'b1010);
        step("t3_w_last",     9'b1_10_0_111_00, 4'b1010);
        step("t3_b_ignored",  9'b1_00_0_000_11, 4'b1010);
        step("t3_aw",         9'b1_10_1_000_00, 4'b1010);
        step("t3_b",          9'b1_00_0_000_11, 4'b0000);

        // AW and WLAST together, then B stalled by BREADY for three cycles.
        step("t4_grant_m1",   9'b1_01_0_000_00, 4'b0110);
        step("t4_aw_last",    9'b1_01_1_111_00, 4'b0110);
        step("t4_bstall1",    9'b1_00_0_000_10, 4'b0110);
        step("t4_bstall2",    9'b1_00_0_000_10, 4'b0110);
        step("t4_bstall3",    9'b1_00_0_000_10, 4'b0110);
        step("t4_b",          9'b1_00_0_000_11, 4'b0000);

        // Overrun: 5 beats with MAX_BEATS=4, flag set on beat 4 and sticky.
        step("t5_grant_m0",   9'b1_10_0_000_00, 4'b1010);
        step("t5_aw",         9'b1_10_1_000_00, 4'b1010);
        step("t5_w1",         9'b1_00_0_101_00, 4'b1010);
        step("t5_w2",         9'b1_00_0_101_00, 4'b1010);
        step("t5_w3",         9'b1_00_0_101_00, 4'b1010);
        step("t5_w4_overrun", 9'b1_00_0_101_00, 4'b1011);
        step("t5_w5_last",    9'b1_00_0_111_00, 4'b1011);
        step("t5_b",          9'b1_00_0_000_11, 4'b0001);
        step("t5_idle",       9'b1_00_0_000_00, 4'b0001);

        // Reset during RESP with m1 owning; afterwards m0 wins contention.
        step("t6_grant_m1",   9'b1_01_0_000_00, 4'b0111);
        step("t6_aw_last",    9'b1_01_1_111_00, 4'b0111);
        step("t6_reset",      9'b0_11_0_000_00, 4'b0000);
        step("t6_grant_m0",   9'b1_11_0_000_00, 4'b1010);
        step("t6_aw_last_m0", 9'b1_11_1_111_00, 4'b1010);
        step("t6_b",          9'b1_00_0_000_11, 4'b0000);
        step("t6_idle",       9'b1_00_0_000_00, 4'b0000);

        // Every queued expectation must have been consumed by the monitor.
        repeat (3) @(posedge ACLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
